idli_fetch_m: RTL and testbench

Instruction fetch sequencer for the decoder. Drives the SQI instruction memory: chip select, address phase, dummy turnaround, then continuous data streaming. Presents the returned data 4b per cycle as the decoder's encoding stream, tracks the fetch PC, and restarts the stream on a backend redirect. Sits between the SQI pads and the decode stage, and owns the fetch PC.

---
 rtl/idli_pkg.sv | 29 ++
 rtl/idli_fetch_m.sv | 124 ++++++++++++
 tb/tb_idli_fetch_m.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared IDLI types and constants used by the fetch sequencer.
// Holds the fetch FSM state encoding, PC/nibble types and the address nibble helper.
package idli_pkg;

    typedef logic [3:0]  sqi_data_t;
    typedef logic [15:0] fetch_pc_t;

    localparam int SQI_ADDR_NIBBLES = 4;

    typedef enum logic [1:0] {
        FCH_DESEL,
        FCH_ADDR,
        FCH_DUMMY,
        FCH_DATA
    } fch_state_t;

    // Address goes out MSB nibble first, so index 0 selects pc[15:12].
    function automatic sqi_data_t pc_nibble(input fetch_pc_t pc, input logic [1:0] idx);
        sqi_data_t nib;
        case (idx)
            2'd0:    nib = pc[15:12];
            2'd1:    nib = pc[11:8];
            2'd2:    nib = pc[7:4];
            default: nib = pc[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/idli_fetch_m.sv
// SQI instruction fetch sequencer: select, address, turnaround, then stream nibbles
// to the decoder while tracking the fetch PC. A redirect restarts the whole transaction.
module idli_fetch_m
    import idli_pkg::*;
#(
    parameter int DUMMY_CYCLES = 2
) (
    input  logic      i_fch_gck,
    input  logic      i_dcd_rst_n,
    output logic      o_sqi_cs_n,
    output logic      o_sqi_sck_en,
    output sqi_data_t o_sqi_sio,
    output logic      o_sqi_sio_oe,
    input  sqi_data_t i_sqi_sio,
    input  logic      i_fch_stall,
    input  logic      i_fch_redir,
    input  fetch_pc_t i_fch_redir_pc,
    output sqi_data_t o_dcd_enc,
    output logic      o_dcd_enc_vld,
    output fetch_pc_t o_fch_pc
);

    localparam logic [1:0] ADDR_LAST  = 2'(SQI_ADDR_NIBBLES - 1);
    localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_CYCLES - 1);

    fch_state_t state_q, state_d;
    logic [1:0] nib_q, nib_d;
    logic [1:0] dmy_q, dmy_d;
    fetch_pc_t  pc_q, pc_d;

    always_ff @(posedge i_fch_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            state_q <= FCH_DESEL;
            nib_q   <= 2'd0;
            dmy_q   <= 2'd0;
            pc_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            dmy_q   <= dmy_d;
            pc_q    <= pc_d;
        end
    end

    // Redirect outranks stall; a stall simply leaves every register holding.
    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        dmy_d   = dmy_q;
        pc_d    = pc_q;
        if (i_fch_redir) begin
            state_d = FCH_DESEL;
            nib_d   = 2'd0;
            dmy_d   = 2'd0;
            pc_d    = i_fch_redir_pc;
        end else if (!i_fch_stall) begin
            case (state_q)
                FCH_DESEL: begin
                    state_d = FCH_ADDR;
                    nib_d   = 2'd0;
                end
                FCH_ADDR: begin
                    nib_d = nib_q + 2'd1;
                    if (nib_q == ADDR_LAST) begin
                        state_d = FCH_DUMMY;
                        dmy_d   = 2'd0;
                    end
                end
                FCH_DUMMY: begin
                    dmy_d = dmy_q + 2'd1;
                    if (dmy_q == DUMMY_LAST) begin
                        state_d = FCH_DATA;
                        nib_d   = 2'd0;
                    end
                end
                default: begin
                    nib_d = nib_q + 2'd1;
                    if (nib_q == 2'd3) begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        o_sqi_cs_n    = 1'b1;
        o_sqi_sck_en  = 1'b0;
        o_sqi_sio_oe  = 1'b0;
        o_sqi_sio     = 4'h0;
        o_dcd_enc     = 4'h0;
        o_dcd_enc_vld = 1'b0;
        case (state_q)
            FCH_ADDR: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
                o_sqi_sio_oe = 1'b1;
                o_sqi_sio    = pc_nibble(pc_q, nib_q);
            end
            FCH_DUMMY: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
            end
            FCH_DATA: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sck_en  = 1'b1;
                o_dcd_enc     = i_sqi_sio;
                o_dcd_enc_vld = 1'b1;
            end
            default: begin
            end
        endcase
        // Stalling gates SCK so the memory holds its position with CS still low.
        if (i_fch_stall && !i_fch_redir) begin
            o_sqi_sck_en = 1'b0;
        end
        if (i_fch_stall || i_fch_redir) begin
            o_dcd_enc_vld = 1'b0;
        end
    end

    assign o_fch_pc = pc_q;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Self-checking bench for idli_fetch_m: an SQI memory device model feeds the DUT,
// outputs are checked against a hand table and a cycle-count based fetch model.
module tb_idli_fetch_m;
    import idli_pkg::*;

    localparam int DUMMY = 2;

    typedef struct {
        logic      stall;
        logic      redir;
        fetch_pc_t rpc;
        logic      csN;
        logic      oe;
        logic      sckEn;
        sqi_data_t sio;
        logic      vld;
        sqi_data_t enc;
        fetch_pc_t pc;
    } vec_t;

    logic      clk;
    logic      rstN;
    logic      csN, sckEn, sioOe, encVld, stall, redir;
    sqi_data_t sioOut, sioIn, enc;
    fetch_pc_t redirPc, fchPc;

    logic [15:0] mem [0:65535];

    int nVec;
    int nErr;

    // Device model state
    int        devPhase;
    int        devCnt;
    int        devNib;
    fetch_pc_t devAddr;

    // Reference model: cycles since transaction start and the PC it started from
    int        mT;
    fetch_pc_t mStart;

    logic      capCs, capSck, capOe, capVld;
    sqi_data_t capSio, capEnc;
    fetch_pc_t capPc;

    idli_fetch_m #(.DUMMY_CYCLES(DUMMY)) dut (
        .i_fch_gck      (clk),
        .i_dcd_rst_n    (rstN),
        .o_sqi_cs_n     (csN),
        .o_sqi_sck_en   (sckEn),
        .o_sqi_sio      (sioOut),
        .o_sqi_sio_oe   (sioOe),
        .i_sqi_sio      (sioIn),
        .i_fch_stall    (stall),
        .i_fch_redir    (redir),
        .i_fch_redir_pc (redirPc),
        .o_dcd_enc      (enc),
        .o_dcd_enc_vld  (encVld),
        .o_fch_pc       (fchPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic cs, input logic oe, input logic sck,
                                input logic vl, input sqi_data_t en, input fetch_pc_t pc);
        vec_t v;
        v.stall = st;
        v.redir = 1'b0;
        v.rpc   = 16'h0000;
        v.csN   = cs;
        v.oe    = oe;
        v.sckEn = sck;
        v.sio   = 4'h0;
        v.vld   = vl;
        v.enc   = en;
        v.pc    = pc;
        return v;
    endfunction

    task automatic devReset();
        devPhase = 0;
        devCnt   = 0;
        devNib   = 0;
        devAddr  = 16'h0000;
    endtask

    function automatic sqi_data_t devOut();
        logic [15:0] w;
        if (devPhase == 2) begin
            w = mem[devAddr];
            return w[(15 - 4 * devNib) -: 4];
        end
        return 4'($urandom);
    endfunction

    // Memory reacts to what the DUT presented on its pins during the cycle just ended.
    task automatic devUpdate();
        if (capCs) begin
            devReset();
        end else if (capSck) begin
            case (devPhase)
                0: begin
                    devAddr = {devAddr[11:0], capSio};
                    devCnt++;
                    if (devCnt == 4) begin
                        devPhase = 1;
                        devCnt   = 0;
                    end
                end
                1: begin
                    devCnt++;
                    if (devCnt == DUMMY) begin
                        devPhase = 2;
                        devNib   = 0;
                    end
                end
                default: begin
                    devNib++;
                    if (devNib == 4) begin
                        devNib  = 0;
                        devAddr = devAddr + 16'd1;
                    end
                end
            endcase
        end
    endtask

    task automatic modelCheck(input logic st, input logic rd);
        int          first;
        int          words;
        int          nib;
        fetch_pc_t   expPc;
        logic [15:0] w;
        logic [15:0] s;
        logic        expVld;
        first  = 5 + DUMMY;
        words  = (mT >= first) ? (mT - first) / 4 : 0;
        nib    = (mT >= first) ? (mT - first) % 4 : 0;
        expPc  = mStart + 16'(words);
        expVld = (mT >= first) && !st && !rd;
        chk("cs_n", 32'(capCs), 32'(mT == 0));
        chk("oe", 32'(capOe), 32'(mT >= 1 && mT <= 4));
        if (!rd) chk("sck_en", 32'(capSck), 32'((mT != 0) && !st));
        if (mT >= 1 && mT <= 4) begin
            s = mStart;
            chk("addr_nibble", 32'(capSio), 32'(s[(15 - 4 * (mT - 1)) -: 4]));
        end
        chk("enc_vld", 32'(capVld), 32'(expVld));
        if (expVld) begin
            w = mem[expPc];
            chk("enc", 32'(capEnc), 32'(w[(15 - 4 * nib) -: 4]));
        end
        chk("fch_pc", 32'(capPc), 32'(expPc));
    endtask

    task automatic applyStimulus(input vec_t v, input bit useTable);
        stall   = v.stall;
        redir   = v.redir;
        redirPc = v.rpc;
        sioIn   = devOut();
        @(negedge clk);
        capCs  = csN;
        capSck = sckEn;
        capOe  = sioOe;
        capSio = sioOut;
        capVld = encVld;
        capEnc = enc;
        capPc  = fchPc;
        if (useTable) begin
            chk("tbl_cs_n", 32'(capCs), 32'(v.csN));
            chk("tbl_oe", 32'(capOe), 32'(v.oe));
            chk("tbl_sck_en", 32'(capSck), 32'(v.sckEn));
            if (v.oe) chk("tbl_sio", 32'(capSio), 32'(v.sio));
            chk("tbl_vld", 32'(capVld), 32'(v.vld));
            if (v.vld) chk("tbl_enc", 32'(capEnc), 32'(v.enc));
            chk("tbl_pc", 32'(capPc), 32'(v.pc));
        end else begin
            modelCheck(v.stall, v.redir);
        end
        @(posedge clk);
        devUpdate();
        if (v.redir) begin
            mStart = v.rpc;
            mT     = 0;
        end else if (!v.stall) begin
            mT++;
        end
        #1;
    endtask

    task automatic step(input logic st, input logic rd, input fetch_pc_t rpc);
        vec_t v;
        v       = mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        v.redir = rd;
        v.rpc   = rpc;
        applyStimulus(v, 1'b0);
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_cs_n"}, 32'(csN), 32'd1);
        chk({tag, "_sck_en"}, 32'(sckEn), 32'd0);
        chk({tag, "_oe"}, 32'(sioOe), 32'd0);
        chk({tag, "_sio"}, 32'(sioOut), 32'd0);
        chk({tag, "_vld"}, 32'(encVld), 32'd0);
        chk({tag, "_pc"}, 32'(fchPc), 32'd0);
    endtask

    initial begin
        vec_t      tbl [$];
        int        lat;
        fetch_pc_t pcA;
        fetch_pc_t pcB;
        nVec    = 0;
        nErr    = 0;
        rstN    = 1'b0;
        stall   = 1'b0;
        redir   = 1'b0;
        redirPc = 16'h0000;
        sioIn   = 4'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0]      = 16'hC123;
        mem[1]      = 16'h4567;
        mem[2]      = 16'h89AB;
        mem[16'h1234] = 16'hBEEF;
        devReset();
        mStart = 16'h0000;
        mT     = 0;

        #1;
        checkOutput("reset");
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;

        // Cycles 0..19 from reset release, with a 3-cycle stall on the second word.
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 16'h0000));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 4'h0, 16'h0000));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 4'h0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'hC, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h2, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h3, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h4, 16'h0001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h5, 16'h0001));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 4'h0, 16'h0001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h6, 16'h0001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h7, 16'h0001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h8, 16'h0002));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'h9, 16'h0002));
        foreach (tbl[i]) applyStimulus(tbl[i], 1'b1);

        // Redirect during DATA: measure cycles until the first valid nibble.
        step(0, 1, 16'h1234);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, 16'h0000);
            if (capVld) begin
                lat = k;
                break;
            end
        end
        chk("redir_latency", 32'(lat), 32'(6 + DUMMY));
        for (int k = 0; k < 6; k++) step(0, 0, 16'h0000);

        // Redirect together with stall while in DUMMY.
        step(0, 1, 16'h0100);
        for (int k = 0; k < 6; k++) step(0, 0, 16'h0000);
        step(1, 1, 16'h2000);
        step(0, 0, 16'h0000);
        chk("redir_stall_desel", 32'(capCs), 32'd1);
        for (int k = 0; k < 10; k++) step(0, 0, 16'h0000);

        // PC wrap at the top of memory: stream must continue without a gap.
        step(0, 1, 16'hFFFF);
        for (int k = 0; k < 6 + DUMMY; k++) step(0, 0, 16'h0000);
        pcA = 16'h1111;
        pcB = 16'h1111;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 16'h0000);
            chk("wrap_vld", 32'(capVld), 32'd1);
            chk("wrap_cs_n", 32'(capCs), 32'd0);
            if (k == 0) pcA = capPc;
            if (k == 4) pcB = capPc;
        end
        chk("wrap_pc_before", 32'(pcA), 32'hFFFF);
        chk("wrap_pc_after", 32'(pcB), 32'h0000);

        // Reset in the middle of the address phase.
        step(0, 1, 16'h5A5A);
        step(0, 0, 16'h0000);
        step(0, 0, 16'h0000);
        rstN = 1'b0;
        #1;
        checkOutput("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN   = 1'b1;
        mStart = 16'h0000;
        mT     = 0;
        devReset();
        for (int k = 0; k < 20; k++) step(0, 0, 16'h0000);

        // Random stall/redirect traffic.
        for (int k = 0; k < 500; k++) begin
            logic      st;
            logic      rd;
            fetch_pc_t rpc;
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 39) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                              : 16'($urandom);
            step(st, rd, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
